// File: rtl/maxpool_pkg.sv
// Shared types and geometry helpers for the max-pool controller.
// Optional feature macro: MAXPOOL_CTRL_ONESCNT_EN (adds a per-row popcount output).
package maxpool_pkg;

  localparam int WL_DEF   = 112;
  localparam int HL_DEF   = 112;
  localparam int POOL_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_READ,
    ST_OUT,
    ST_DONE
  } state_e;

  // Output columns per pooled row.
  function automatic int calc_ow(int wl, int pool);
    return wl / pool;
  endfunction

  // Index width for n entries, never narrower than one bit.
  function automatic int calc_aw(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxpool_ctrl_if.sv
// Bundle between the controller and the pool-unit bit array.
// The controller drives writes/clears; the pool unit returns its whole row.
interface maxpool_ctrl_if #(
  parameter int OW = 4,
  parameter int AW = 2
);
  logic          clr;
  logic          wr_en;
  logic          rd_en;
  logic          wr_data;
  logic [AW-1:0] addr;
  logic [OW-1:0] pool_data;

  modport master (output clr, wr_en, rd_en, wr_data, addr, input  pool_data);
  modport slave  (input  clr, wr_en, rd_en, wr_data, addr, output pool_data);
endinterface

// File: rtl/maxpool_popcnt.sv
// Combinational population count of a W-bit vector.
module maxpool_popcnt #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
)(
  input  logic [W-1:0]  vec_i,
  output logic [CW-1:0] cnt_o
);

  // Plain adder chain; W is the pooled-row width so it stays small.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) cnt_o = cnt_o + CW'(vec_i[i]);
  end

endmodule

// File: rtl/maxpool_ctrl.sv
// Max-pool (binary OR) controller: streams pixels into an external pool
// unit, reads each pooled row back and hands it out with a valid/ready pair.
// Optional feature macro: MAXPOOL_CTRL_ONESCNT_EN adds oONES (row popcount).
module maxpool_ctrl
  import maxpool_pkg::*;
#(
  parameter  int WL   = WL_DEF,
  parameter  int HL   = HL_DEF,
  parameter  int POOL = POOL_DEF,
  localparam int OW   = calc_ow(WL, POOL),
  localparam int AW   = calc_aw(OW),
  localparam int ONW  = $clog2(OW + 1)
)(
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iSTART,
  input  logic          iABORT,
  input  logic          iVALID,
  input  logic          iDATA,
  output logic          oREADY,
  output logic          oCLR,
  output logic          oWriteEN,
  output logic          oReadEN,
  output logic          oPoolDATA,
  output logic [AW-1:0] oADDR,
  input  logic [OW-1:0] iPoolDATA,
  output logic [OW-1:0] oROW,
  output logic          oROW_VALID,
  input  logic          iROW_READY,
  output logic          oBUSY,
  output logic          oDONE
`ifdef MAXPOOL_CTRL_ONESCNT_EN
  ,
  output logic [ONW-1:0] oONES
`endif
);

  localparam int NR = HL / POOL;
  localparam int CW = calc_aw(WL);
  localparam int WW = calc_aw(POOL);
  localparam int RW = calc_aw(NR);

  // Frame geometry must tile exactly into pooling windows.
  generate
    if ((WL % POOL) != 0 || (HL % POOL) != 0) begin : g_bad_geom
      $error("maxpool_ctrl: WL and HL must be multiples of POOL");
    end
  endgenerate

  state_e        state_q;
  logic [CW-1:0] col_q;
  logic [WW-1:0] win_q;
  logic [RW-1:0] orow_q;
  logic [OW-1:0] row_q;

  logic accept;
  logic col_last, win_last, orow_last;

  assign accept    = (state_q == ST_ACCUM) && iVALID && !iABORT;
  assign col_last  = (col_q  == CW'(WL - 1));
  assign win_last  = (win_q  == WW'(POOL - 1));
  assign orow_last = (orow_q == RW'(NR - 1));

  // Output decodes of the registered state; abort gates the pixel path.
  assign oREADY     = (state_q == ST_ACCUM);
  assign oWriteEN   = accept;
  assign oPoolDATA  = iDATA;
  assign oADDR      = AW'(int'(col_q) / POOL);
  assign oCLR       = iABORT || (state_q == ST_CLEAR);
  assign oReadEN    = (state_q == ST_READ);
  assign oROW_VALID = (state_q == ST_OUT);
  assign oDONE      = (state_q == ST_DONE);
  assign oBUSY      = (state_q != ST_IDLE);
  assign oROW       = row_q;

`ifdef MAXPOOL_CTRL_ONESCNT_EN
  logic [ONW-1:0] ones_cnt;
  logic [ONW-1:0] ones_q;

  maxpool_popcnt #(.W(OW), .CW(ONW)) u_popcnt (
    .vec_i (iPoolDATA),
    .cnt_o (ones_cnt)
  );

  // Popcount is captured together with the row so both share oROW_VALID.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn)                             ones_q <= '0;
    else if (!iABORT && state_q == ST_READ) ones_q <= ones_cnt;
  end

  assign oONES = ones_q;
`endif

  // Main sequencer: state, window counters and the captured pooled row.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      win_q   <= '0;
      orow_q  <= '0;
      row_q   <= '0;
    end else if (iABORT) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      win_q   <= '0;
      orow_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE:  if (iSTART) state_q <= ST_CLEAR;
        ST_CLEAR: state_q <= ST_ACCUM;
        ST_ACCUM: begin
          if (accept) begin
            if (col_last) begin
              col_q <= '0;
              if (win_last) begin
                win_q   <= '0;
                state_q <= ST_READ;
              end else begin
                win_q <= win_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        ST_READ: begin
          row_q   <= iPoolDATA;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          if (iROW_READY) begin
            if (orow_last) begin
              orow_q  <= '0;
              state_q <= ST_DONE;
            end else begin
              orow_q  <= orow_q + 1'b1;
              state_q <= ST_CLEAR;
            end
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Self-checking bench for maxpool_ctrl at WL=8, HL=4, POOL=2.
// Expected pooled rows come from a direct window-OR over a frame image.
module tb_maxpool_ctrl;

  localparam int WL   = 8;
  localparam int HL   = 4;
  localparam int POOL = 2;
  localparam int OW   = WL / POOL;
  localparam int AW   = 2;
  localparam int NR   = HL / POOL;

  logic iCLK = 1'b0;
  logic iRSTn, iSTART, iABORT, iVALID, iDATA, iROW_READY;
  logic oREADY, oROW_VALID, oBUSY, oDONE;
  logic [OW-1:0] oROW;
`ifdef MAXPOOL_CTRL_ONESCNT_EN
  logic [2:0] oONES;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [WL-1:0] img     [HL];
  logic [OW-1:0] exp_row [NR];

  maxpool_ctrl_if #(.OW(OW), .AW(AW)) pif ();

  // Behavioural pool unit: a bit array OR-accumulating writes, cleared by clr.
  logic [OW-1:0] pool = '1;
  always @(posedge iCLK) begin
    if (pif.clr)        pool <= '0;
    else if (pif.wr_en) pool[pif.addr] <= pool[pif.addr] | pif.wr_data;
  end
  assign pif.pool_data = pool;

  maxpool_ctrl #(.WL(WL), .HL(HL), .POOL(POOL)) dut (
    .iCLK       (iCLK),
    .iRSTn      (iRSTn),
    .iSTART     (iSTART),
    .iABORT     (iABORT),
    .iVALID     (iVALID),
    .iDATA      (iDATA),
    .oREADY     (oREADY),
    .oCLR       (pif.clr),
    .oWriteEN   (pif.wr_en),
    .oReadEN    (pif.rd_en),
    .oPoolDATA  (pif.wr_data),
    .oADDR      (pif.addr),
    .iPoolDATA  (pif.pool_data),
    .oROW       (oROW),
    .oROW_VALID (oROW_VALID),
    .iROW_READY (iROW_READY),
    .oBUSY      (oBUSY),
    .oDONE      (oDONE)
`ifdef MAXPOOL_CTRL_ONESCNT_EN
    ,
    .oONES      (oONES)
`endif
  );

  always #5 iCLK = ~iCLK;

  // Reference: oROW[k] of pooled row r is the OR over its POOLxPOOL window.
  task automatic build_expected();
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < OW; k++) begin
        logic b;
        b = 1'b0;
        for (int w = 0; w < POOL; w++)
          for (int j = 0; j < POOL; j++) b = b | img[POOL*r+w][POOL*k+j];
        exp_row[r][k] = b;
      end
  endtask

  task automatic randomize_image();
    for (int r = 0; r < HL; r++) img[r] = WL'($urandom);
  endtask

  // Drives one full frame, checking every cycle against the reference.
  // gap_pct: chance of an idle iVALID cycle; bp_lo..bp_hi: stall cycles in OUT.
  task automatic run_frame(input string tag, input int gap_pct, input int bp_lo, input int bp_hi);
    int bp;
    build_expected();
    @(negedge iCLK); iSTART = 1'b1; #1;
    n_chk++; if (oBUSY !== 1'b0) begin n_fail++; $display("FAIL %s idle_busy got %b want 0", tag, oBUSY); end
    @(negedge iCLK); iSTART = 1'b0; #1;
    n_chk++; if (pif.clr !== 1'b1 || oBUSY !== 1'b1) begin n_fail++; $display("FAIL %s start_clear clr=%b busy=%b want 1 1", tag, pif.clr, oBUSY); end
    for (int r = 0; r < NR; r++) begin
      if (r > 0) begin
        @(negedge iCLK); iROW_READY = 1'b0; #1;
        n_chk++; if (pif.clr !== 1'b1 || oREADY !== 1'b0) begin n_fail++; $display("FAIL %s row_clear clr=%b ready=%b want 1 0", tag, pif.clr, oREADY); end
      end
      for (int p = 0; p < POOL*WL; p++) begin
        int w, c, gaps;
        w = p / WL; c = p % WL; gaps = 0;
        while (gaps < 3 && int'($urandom_range(99)) < gap_pct) begin
          gaps++;
          @(negedge iCLK); iVALID = 1'b0; iDATA = 1'($urandom); iSTART = 1'($urandom); #1;
          n_chk++; if (oREADY !== 1'b1 || pif.wr_en !== 1'b0 || pif.clr !== 1'b0) begin n_fail++; $display("FAIL %s gap r%0d p%0d ready=%b we=%b clr=%b want 1 0 0", tag, r, p, oREADY, pif.wr_en, pif.clr); end
        end
        @(negedge iCLK); iVALID = 1'b1; iDATA = img[POOL*r+w][c]; iSTART = 1'b0; #1;
        n_chk++; if (oREADY !== 1'b1 || pif.wr_en !== 1'b1 || pif.clr !== 1'b0 || pif.addr !== AW'(c/POOL) || pif.wr_data !== img[POOL*r+w][c])
          begin n_fail++; $display("FAIL %s pixel r%0d p%0d ready=%b we=%b clr=%b addr=%0d want addr %0d", tag, r, p, oREADY, pif.wr_en, pif.clr, pif.addr, c/POOL); end
      end
      @(negedge iCLK); iVALID = 1'($urandom); iDATA = 1'($urandom); #1;
      n_chk++; if (pif.rd_en !== 1'b1 || oREADY !== 1'b0 || pif.wr_en !== 1'b0) begin n_fail++; $display("FAIL %s read r%0d rd=%b ready=%b we=%b want 1 0 0", tag, r, pif.rd_en, oREADY, pif.wr_en); end
      bp = int'($urandom_range(bp_hi, bp_lo));
      for (int b = 0; b < bp; b++) begin
        @(negedge iCLK); iROW_READY = 1'b0; iVALID = 1'b1; #1;
        n_chk++; if (oROW_VALID !== 1'b1 || oROW !== exp_row[r] || oREADY !== 1'b0 || pif.clr !== 1'b0)
          begin n_fail++; $display("FAIL %s stall r%0d valid=%b row=%b want %b ready=%b clr=%b", tag, r, oROW_VALID, oROW, exp_row[r], oREADY, pif.clr); end
      end
      @(negedge iCLK); iROW_READY = 1'b1; iVALID = 1'b0; #1;
      n_chk++; if (oROW_VALID !== 1'b1 || oROW !== exp_row[r]) begin n_fail++; $display("FAIL %s row r%0d valid=%b got %b want %b", tag, r, oROW_VALID, oROW, exp_row[r]); end
`ifdef MAXPOOL_CTRL_ONESCNT_EN
      n_chk++; if (oONES !== 3'($countones(exp_row[r]))) begin n_fail++; $display("FAIL %s ones r%0d got %0d want %0d", tag, r, oONES, $countones(exp_row[r])); end
`endif
    end
    @(negedge iCLK); iROW_READY = 1'b0; #1;
    n_chk++; if (oDONE !== 1'b1 || oBUSY !== 1'b1 || oROW_VALID !== 1'b0) begin n_fail++; $display("FAIL %s done done=%b busy=%b valid=%b want 1 1 0", tag, oDONE, oBUSY, oROW_VALID); end
    @(negedge iCLK); #1;
    n_chk++; if (oDONE !== 1'b0 || oBUSY !== 1'b0) begin n_fail++; $display("FAIL %s after_done done=%b busy=%b want 0 0", tag, oDONE, oBUSY); end
  endtask

  task automatic test_reset();
    iRSTn = 1'b0; iSTART = 1'b0; iABORT = 1'b0; iVALID = 1'b0; iDATA = 1'b0; iROW_READY = 1'b0;
    repeat (3) @(negedge iCLK);
    #1;
    n_chk++; if ({oREADY, pif.clr, pif.wr_en, pif.rd_en, oROW_VALID, oBUSY, oDONE, oROW} !== '0)
      begin n_fail++; $display("FAIL reset_outputs got %b want all 0", {oREADY, pif.clr, pif.wr_en, pif.rd_en, oROW_VALID, oBUSY, oDONE, oROW}); end
    @(negedge iCLK); iRSTn = 1'b1;
  endtask

  task automatic test_pooling();
    img[0] = 8'b1000_0001; img[1] = 8'b0000_0000;
    img[2] = 8'b0011_0000; img[3] = 8'b0000_0100;
    build_expected();
    n_chk++; if (exp_row[0] !== 4'b1001) begin n_fail++; $display("FAIL model_row0 got %b want 1001", exp_row[0]); end
    run_frame("pooling", 0, 0, 0);
  endtask

  task automatic test_gaps();
    img[0] = 8'b0100_0010; img[1] = 8'b0001_0000;
    img[2] = 8'b1000_0000; img[3] = 8'b0000_0001;
    run_frame("gaps", 50, 0, 1);
    run_frame("nogaps", 0, 0, 0);
  endtask

  task automatic test_backpressure();
    randomize_image();
    run_frame("backpressure", 20, 5, 5);
  endtask

  task automatic test_abort();
    @(negedge iCLK); iSTART = 1'b1;
    @(negedge iCLK); iSTART = 1'b0;
    for (int p = 0; p < WL + 5; p++) begin
      @(negedge iCLK); iVALID = 1'b1; iDATA = 1'b1;
    end
    @(negedge iCLK); iVALID = 1'b1; iDATA = 1'b1; iABORT = 1'b1; iSTART = 1'b1; #1;
    n_chk++; if (pif.clr !== 1'b1 || pif.wr_en !== 1'b0) begin n_fail++; $display("FAIL abort_cycle clr=%b we=%b want 1 0", pif.clr, pif.wr_en); end
    @(negedge iCLK); iABORT = 1'b0; iSTART = 1'b0; iVALID = 1'b0; #1;
    n_chk++; if (oBUSY !== 1'b0 || oREADY !== 1'b0 || oROW_VALID !== 1'b0 || pif.clr !== 1'b0)
      begin n_fail++; $display("FAIL abort_idle busy=%b ready=%b valid=%b clr=%b want 0 0 0 0", oBUSY, oREADY, oROW_VALID, pif.clr); end
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK); #1;
      n_chk++; if (oROW_VALID !== 1'b0 || oBUSY !== 1'b0) begin n_fail++; $display("FAIL abort_quiet valid=%b busy=%b want 0 0", oROW_VALID, oBUSY); end
    end
    randomize_image();
    run_frame("after_abort", 10, 0, 2);
  endtask

  task automatic test_reset_midframe();
    @(negedge iCLK); iSTART = 1'b1;
    @(negedge iCLK); iSTART = 1'b0;
    for (int p = 0; p < 6; p++) begin
      @(negedge iCLK); iVALID = 1'b1; iDATA = 1'b1;
    end
    @(negedge iCLK); #2 iRSTn = 1'b0; #1;
    n_chk++; if ({oREADY, pif.clr, pif.wr_en, pif.rd_en, oROW_VALID, oBUSY, oDONE, oROW} !== '0)
      begin n_fail++; $display("FAIL midframe_reset got %b want all 0", {oREADY, pif.clr, pif.wr_en, pif.rd_en, oROW_VALID, oBUSY, oDONE, oROW}); end
    repeat (3) @(negedge iCLK);
    iRSTn = 1'b1; iVALID = 1'b0; #1;
    n_chk++; if (oBUSY !== 1'b0 || oREADY !== 1'b0) begin n_fail++; $display("FAIL post_reset busy=%b ready=%b want 0 0", oBUSY, oREADY); end
    for (int r = 0; r < HL; r++) img[r] = '0;
    run_frame("reset_flush", 0, 0, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      randomize_image();
      run_frame("random", 30, 0, 3);
    end
  endtask

  initial begin
    test_reset();
    test_pooling();
    test_gaps();
    test_backpressure();
    test_abort();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
